// File: rtl/sram_host_ctrl.sv
// Burst initiator driving a single-port SRAM (write at negedge, combinational read).
// Optional macro SRAM_HOST_BOUND_CHK_EN drops bursts that would run past the last word.
`timescale 1ns/1ps
module sram_host_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_wr,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [WIDTH-1:0] wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_last,
  output logic             busy,
  output logic             cmd_err,
  output logic             sram_en,
  output logic             sram_wr,
  output logic [DEPTH-1:0] sram_addr,
  output logic [WIDTH-1:0] sram_wdata,
  input  logic [WIDTH-1:0] sram_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_WAIT = 3'd1,
    WR_DO   = 3'd2,
    RD_DO   = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [AW-1:0]    addr_r, addr_s;
  logic [LEN_W-1:0] rem_r, rem_s;
  logic             cmd_ready_r, wdata_ready_r, rsp_valid_r, rsp_last_r;
  logic             busy_r, cmd_err_r, sram_en_r, sram_wr_r;
  logic [WIDTH-1:0] rsp_data_r, sram_wdata_r;
  logic [DEPTH-1:0] sram_addr_r;
  logic             cmd_fire_s, wdata_fire_s, rsp_fire_s, bound_err_s;

  assign cmd_fire_s   = cmd_valid && cmd_ready_r;
  assign wdata_fire_s = wdata_valid && wdata_ready_r;
  assign rsp_fire_s   = rsp_valid_r && rsp_ready;

`ifdef SRAM_HOST_BOUND_CHK_EN
  localparam logic [AW+LEN_W:0] LAST_ADDR = (AW+LEN_W+1)'(DEPTH-1);
  logic [AW+LEN_W:0] end_addr_s;
  assign end_addr_s  = {{(LEN_W+1){1'b0}}, cmd_addr} + {{(AW+1){1'b0}}, cmd_len};
  assign bound_err_s = (end_addr_s > LAST_ADDR);
`else
  assign bound_err_s = 1'b0;
`endif

  // Next-state, address and beat-count computation
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    rem_s   = rem_r;
    case (state_r)
      IDLE: begin
        if (cmd_fire_s && !bound_err_s) begin
          addr_s  = cmd_addr;
          rem_s   = cmd_len;
          state_s = cmd_wr ? WR_WAIT : RD_DO;
        end else begin
          state_s = IDLE;
        end
      end
      WR_WAIT: begin
        if (wdata_fire_s) begin
          state_s = WR_DO;
        end else begin
          state_s = WR_WAIT;
        end
      end
      WR_DO: begin
        if (rem_r == {LEN_W{1'b0}}) begin
          state_s = IDLE;
        end else begin
          addr_s  = addr_r + ADDR_ONE;
          rem_s   = rem_r - LEN_ONE;
          state_s = WR_WAIT;
        end
      end
      RD_DO: begin
        state_s = RD_RESP;
      end
      RD_RESP: begin
        if (!rsp_fire_s) begin
          state_s = RD_RESP;
        end else if (rsp_last_r) begin
          state_s = IDLE;
        end else begin
          addr_s  = addr_r + ADDR_ONE;
          rem_s   = rem_r - LEN_ONE;
          state_s = RD_DO;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and all outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      addr_r        <= {AW{1'b0}};
      rem_r         <= {LEN_W{1'b0}};
      cmd_ready_r   <= 1'b0;
      wdata_ready_r <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= {WIDTH{1'b0}};
      rsp_last_r    <= 1'b0;
      busy_r        <= 1'b0;
      cmd_err_r     <= 1'b0;
      sram_en_r     <= 1'b0;
      sram_wr_r     <= 1'b0;
      sram_addr_r   <= {DEPTH{1'b0}};
      sram_wdata_r  <= {WIDTH{1'b0}};
    end else begin
      state_r       <= state_s;
      addr_r        <= addr_s;
      rem_r         <= rem_s;
      cmd_ready_r   <= (state_s == IDLE);
      wdata_ready_r <= (state_s == WR_WAIT);
      busy_r        <= (state_s != IDLE);
      sram_en_r     <= (state_s == WR_DO) || (state_s == RD_DO);
      sram_wr_r     <= (state_s == WR_DO);
      cmd_err_r     <= cmd_fire_s && bound_err_s;
      if ((state_s == WR_DO) || (state_s == RD_DO)) begin
        sram_addr_r <= {{(DEPTH-AW){1'b0}}, addr_s};
      end
      if (wdata_fire_s) begin
        sram_wdata_r <= wdata;
      end
      // Read word is sampled at the edge that closes the RD_DO cycle
      if (state_r == RD_DO) begin
        rsp_data_r  <= sram_rdata;
        rsp_valid_r <= 1'b1;
        rsp_last_r  <= (rem_r == {LEN_W{1'b0}});
      end else if (rsp_fire_s) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign wdata_ready = wdata_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_data    = rsp_data_r;
  assign rsp_last    = rsp_last_r;
  assign busy        = busy_r;
  assign cmd_err     = cmd_err_r;
  assign sram_en     = sram_en_r;
  assign sram_wr     = sram_wr_r;
  assign sram_addr   = sram_addr_r;
  assign sram_wdata  = sram_wdata_r;

endmodule
